// File: rtl/frame_sequencer_pkg.sv
// Shared definitions for the frame sequencer.
//   state_t  : sequencer state encoding (IDLE, ISSUE, WAIT, DONE, ERR)
//   OP_PUSH  : op value selecting a frame push (write, stack grows down)
//   OP_POP   : op value selecting a frame pop (read, stack shrinks up)
package frame_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

endpackage

// File: rtl/frame_sequencer_wait_timer.sv
// Per-word wait timer for the frame sequencer.
//   clk, reset : clock and asynchronous active-high reset
//   clear      : restart the count at 0 (held during the issue cycle)
//   enable     : count one wait cycle
//   expired    : the current wait cycle is the TIMEOUT-th one for this word
module wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] count;

  // count holds (number of wait cycles already elapsed), so it reads
  // TIMEOUT-1 during the TIMEOUT-th wait cycle.
  assign expired = (count == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/frame_sequencer.sv
// Frame sequencer: moves an NWORDS-word frame between a register frame and a
// memory-resident stack, one handshaken access per word.
//   clk, reset          : clock, asynchronous active-high reset
//   start, op, sp_in    : request (op 0 = push, 1 = pop) and starting stack ptr
//   src_data            : frame to push, slot k at [k*DATA_W +: DATA_W]
//   mem_req/we/addr/wdata, mem_rdata, dataReady : memory access port
//   busy, done, err     : status (done/err are one-cycle pulses)
//   sp_out, dst_data    : updated stack pointer, popped frame
module frame_sequencer
  import frame_sequencer_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 12,
  parameter int NWORDS  = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     op,
  input  logic [ADDR_W-1:0]        sp_in,
  input  logic [NWORDS*DATA_W-1:0] src_data,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     dataReady,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [ADDR_W-1:0]        sp_out,
  output logic [NWORDS*DATA_W-1:0] dst_data
);

  // Word index width; word arrays are padded to a power of two so every
  // index value of k selects a real entry.
  localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int NSLOT = 2 ** IW;

  state_t              state;
  logic                op_q;
  logic [ADDR_W-1:0]   sp_q;
  logic [NWORDS*DATA_W-1:0] src_q;
  logic [IW-1:0]       k;
  logic                expired;

  logic [DATA_W-1:0]   src_words [NSLOT];
  logic [DATA_W-1:0]   dst_words [NSLOT];

  logic [IW-1:0]       k_inc;
  logic [IW-1:0]       dst_idx;

  assign k_inc   = k + IW'(1);
  // Pop fills slots from the top down so the frame comes back in push order.
  assign dst_idx = IW'(NWORDS - 1) - k;

  for (genvar gi = 0; gi < NSLOT; gi++) begin : g_src
    if (gi < NWORDS) begin : g_used
      assign src_words[gi] = src_q[gi*DATA_W +: DATA_W];
    end else begin : g_pad
      assign src_words[gi] = '0;
    end
  end

  for (genvar gi = 0; gi < NWORDS; gi++) begin : g_dst
    assign dst_data[gi*DATA_W +: DATA_W] = dst_words[gi];
  end

  // Push walks down from sp-1, pop walks up from sp; both wrap naturally.
  function automatic logic [ADDR_W-1:0] word_addr(input logic op_f,
                                                  input logic [ADDR_W-1:0] sp,
                                                  input logic [IW-1:0] idx);
    if (op_f == OP_PUSH) return sp - ADDR_W'(1) - ADDR_W'(idx);
    else                 return sp + ADDR_W'(idx);
  endfunction

  wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (state == ST_ISSUE),
    .enable (state == ST_WAIT),
    .expired(expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      op_q      <= OP_PUSH;
      sp_q      <= '0;
      src_q     <= '0;
      k         <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      sp_out    <= '0;
      for (int i = 0; i < NSLOT; i++) dst_words[i] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q      <= op;
            sp_q      <= sp_in;
            src_q     <= src_data;
            k         <= '0;
            state     <= ST_ISSUE;
            busy      <= 1'b1;
            mem_req   <= 1'b1;
            mem_we    <= (op == OP_PUSH);
            mem_addr  <= word_addr(op, sp_in, '0);
            mem_wdata <= (op == OP_PUSH) ? src_data[DATA_W-1:0] : '0;
          end
        end
        ST_ISSUE: begin
          // Address, direction and write data are left untouched until the
          // word completes so the memory sees a stable request.
          mem_req <= 1'b0;
          state   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (dataReady) begin
            if (op_q == OP_POP) dst_words[dst_idx] <= mem_rdata;
            if (k == IW'(NWORDS - 1)) begin
              state  <= ST_DONE;
              done   <= 1'b1;
              sp_out <= (op_q == OP_PUSH) ? sp_q - ADDR_W'(NWORDS)
                                          : sp_q + ADDR_W'(NWORDS);
            end else begin
              k         <= k_inc;
              state     <= ST_ISSUE;
              mem_req   <= 1'b1;
              mem_addr  <= word_addr(op_q, sp_q, k_inc);
              mem_wdata <= (op_q == OP_PUSH) ? src_words[k_inc] : '0;
            end
          end else if (expired) begin
            state <= ST_ERR;
            err   <= 1'b1;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        ST_ERR: begin
          err   <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// Testbench for frame_sequencer: table of frame transfers driven against a
// behavioural memory, with expected accesses queued at start and compared as
// each mem_req appears, plus a hand-written mid-transfer reset sequence.
module tb_frame_sequencer;
  import frame_sequencer_pkg::*;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 12;
  localparam int NWORDS  = 4;
  localparam int TIMEOUT = 15;

  logic                     clk;
  logic                     reset;
  logic                     start;
  logic                     op;
  logic [ADDR_W-1:0]        sp_in;
  logic [NWORDS*DATA_W-1:0] src_data;
  logic                     mem_req;
  logic                     mem_we;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_wdata;
  logic [DATA_W-1:0]        mem_rdata;
  logic                     dataReady;
  logic                     busy;
  logic                     done;
  logic                     err;
  logic [ADDR_W-1:0]        sp_out;
  logic [NWORDS*DATA_W-1:0] dst_data;

  frame_sequencer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NWORDS(NWORDS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .sp_in(sp_in),
    .src_data(src_data), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dataReady(dataReady), .busy(busy), .done(done), .err(err),
    .sp_out(sp_out), .dst_data(dst_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem [0:4095];
  assign mem_rdata = mem[mem_addr];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [15:0] wdata;
  } acc_t;

  acc_t exp_q[$];

  typedef struct {
    logic        op;
    logic [11:0] sp;
    logic [63:0] src;
    int          lat;       // extra WAIT cycles before dataReady
    int          stall;     // word whose dataReady is withheld, -1 = none
    logic        hold;      // dataReady held high + stray start while busy
    logic        exp_err;
    logic [11:0] exp_sp;
    logic [63:0] exp_dst;
    int          exp_cycle; // cycle of done/err pulse, start cycle = 0
  } vec_t;

  vec_t vecs[7];

  task automatic run_frame(input string tag, input vec_t v);
    int   nw, word, wcyc, nacc, done_c, err_c;
    bit   outst, fin;
    acc_t e;
    logic [12:0] last;
    nw = (v.stall >= 0) ? v.stall + 1 : NWORDS;
    for (int k = 0; k < nw; k++) begin
      e.we    = (v.op == OP_PUSH);
      e.addr  = (v.op == OP_PUSH) ? v.sp - 12'(1) - 12'(k) : v.sp + 12'(k);
      e.wdata = (v.op == OP_PUSH) ? v.src[k*16 +: 16] : 16'h0;
      exp_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b1; op = v.op; sp_in = v.sp; src_data = v.src;
    done_c = -1; err_c = -1; outst = 0; fin = 0; word = -1; wcyc = 0;
    nacc = 0; last = '0;
    for (int c = 1; c <= 200 && !fin; c++) begin
      @(negedge clk);
      start = v.hold && (c == 3);
      if (v.hold) sp_in = 12'h7AA;
      if (done) begin done_c = c; fin = 1; end
      if (err)  begin err_c  = c; fin = 1; end
      dataReady = v.hold;
      if (mem_req) begin
        nacc++; word++; outst = 1; wcyc = 0;
        last = {mem_we, mem_addr};
        if (exp_q.size() == 0) begin
          check("unexpected_access", {mem_we, mem_addr}, 64'h0);
        end else begin
          e = exp_q.pop_front();
          check("acc_dir_addr", {mem_we, mem_addr}, {e.we, e.addr});
          if (e.we) begin
            check("acc_wdata", mem_wdata, e.wdata);
            mem[mem_addr] = mem_wdata;
          end
        end
      end else if (outst) begin
        wcyc++;
        check("addr_stable", {mem_we, mem_addr}, last);
        if (wcyc == v.lat + 1 && word != v.stall) begin
          dataReady = 1'b1;
          outst = 0;
        end
      end
    end
    dataReady = 1'b0; start = 1'b0;
    check("finished", fin, 1);
    check("end_cycle", v.exp_err ? err_c : done_c, v.exp_cycle);
    check("done_seen", done_c >= 0, !v.exp_err);
    check("err_seen", err_c >= 0, v.exp_err);
    check("sp_out", sp_out, v.exp_sp);
    check("dst_data", dst_data, v.exp_dst);
    check("acc_count", nacc, nw);
    check("acc_left", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    check("pulse_end", {done, err, busy}, 3'b000);
    $display("%s op=%0d sp=%h end_cycle=%0d sp_out=%h dst=%h accesses=%0d",
             tag, v.op, v.sp, v.exp_err ? err_c : done_c, sp_out, dst_data,
             nacc);
  endtask

  initial begin
    int got;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    reset = 1'b1; start = 1'b0; op = OP_PUSH; sp_in = '0; src_data = '0;
    dataReady = 1'b0;

    vecs[0] = '{OP_PUSH, 12'h100, 64'h4444_3333_2222_1111, 0,  -1, 1'b0,
                1'b0, 12'h0FC, 64'h0, 9};
    vecs[1] = '{OP_POP,  12'h0FC, 64'h0, 0, -1, 1'b0,
                1'b0, 12'h100, 64'h4444_3333_2222_1111, 9};
    vecs[2] = '{OP_PUSH, 12'h002, 64'hDEAD_BEEF_CAFE_F00D, 2, -1, 1'b0,
                1'b0, 12'hFFE, 64'h4444_3333_2222_1111, 17};
    vecs[3] = '{OP_POP,  12'hFFE, 64'h0, 3, -1, 1'b0,
                1'b0, 12'h002, 64'hDEAD_BEEF_CAFE_F00D, 21};
    vecs[4] = '{OP_PUSH, 12'h200, 64'h5555_6666_7777_8888, 0, 2, 1'b0,
                1'b1, 12'h002, 64'hDEAD_BEEF_CAFE_F00D, 21};
    vecs[5] = '{OP_POP,  12'h0FC, 64'h0, 14, -1, 1'b0,
                1'b0, 12'h100, 64'h4444_3333_2222_1111, 65};
    vecs[6] = '{OP_PUSH, 12'h300, 64'h0123_4567_89AB_CDEF, 0, -1, 1'b1,
                1'b0, 12'h2FC, 64'h4444_3333_2222_1111, 9};

    repeat (2) @(negedge clk);
    check("reset_outputs",
          {mem_req, mem_we, busy, done, err, mem_addr, mem_wdata, sp_out},
          45'h0);
    check("reset_dst", dst_data, 64'h0);
    reset = 1'b0;
    $display("reset released outputs=%h dst=%h", {busy, done, err, sp_out},
             dst_data);

    for (int i = 0; i < 7; i++) run_frame($sformatf("vec%0d", i), vecs[i]);

    // Reset during the WAIT of word 1: outputs must clear without a clock.
    @(negedge clk);
    start = 1'b1; op = OP_PUSH; sp_in = 12'h050;
    src_data = 64'h1111_2222_3333_4444;
    dataReady = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < 2; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (mem_req) got++;
    end
    check("reset_setup_reqs", got, 2);
    dataReady = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_reset_outputs",
          {mem_req, mem_we, busy, done, err, mem_addr, mem_wdata, sp_out},
          45'h0);
    check("async_reset_dst", dst_data, 64'h0);
    $display("mid-transfer reset outputs=%h dst=%h",
             {busy, done, err, sp_out}, dst_data);
    @(negedge clk);
    check("reset_no_pulse", {done, err}, 2'b00);
    reset = 1'b0;

    run_frame("post_reset", '{OP_PUSH, 12'h050, 64'h0A0A_0B0B_0C0C_0D0D, 1,
                              -1, 1'b0, 1'b0, 12'h04C, 64'h0, 13});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
